// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer slice: size defaults, note frequency
// table and the voice allocator state encoding.
package synth_pkg;

    localparam int NUM_KEYS_DEF   = 13;
    localparam int NUM_VOICES_DEF = 4;
    localparam int KEY_W_DEF      = 4;
    localparam int AGE_W_DEF      = 8;

    // Tone frequency in Hz for each note index, C2 up to C3.
    localparam int NOTE_HZ [NUM_KEYS_DEF] = '{
        65, 69, 73, 78, 82, 87, 92, 98, 104, 110, 117, 123, 131
    };

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        ALLOC   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic int note_hz(input int idx);
        return (idx >= 0 && idx < NUM_KEYS_DEF) ? NOTE_HZ[idx] : 0;
    endfunction

endpackage

// File: rtl/voice_select.sv
// Picks the slot for a new note: lowest free slot, otherwise the oldest busy
// slot (lowest index on equal age), flagging the latter as a steal.
module voice_select
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int AGE_W      = AGE_W_DEF,
    parameter int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0]       voice_active,
    input  logic [NUM_VOICES*AGE_W-1:0] ages,
    output logic [VIDX_W-1:0]           target,
    output logic                        steal
);

    logic             found_free;
    logic [AGE_W-1:0] best_age;

    always_comb begin
        target     = '0;
        steal      = 1'b0;
        found_free = 1'b0;
        best_age   = '0;
        // Descending walk so the lowest free index is the last one written.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                target     = VIDX_W'(v);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            steal    = 1'b1;
            target   = '0;
            best_age = ages[0 +: AGE_W];
            // Strict compare keeps the lowest index on ties.
            for (int v = 1; v < NUM_VOICES; v++) begin
                if (ages[v*AGE_W +: AGE_W] > best_age) begin
                    best_age = ages[v*AGE_W +: AGE_W];
                    target   = VIDX_W'(v);
                end
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: scans the synchronized key bitmap one key per cycle
// and maps press/release events onto a small pool of voice slots.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int KEY_W      = KEY_W_DEF,
    parameter int AGE_W      = AGE_W_DEF
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic [NUM_KEYS-1:0]         keys,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]       voice_trig,
    output logic                        steal,
    output logic                        busy
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_KEYS-1:0]         key_sync_p0;
    logic [NUM_KEYS-1:0]         key_sync_p1;
    logic [NUM_KEYS-1:0]         key_state;
    logic [KEY_W-1:0]            scan_ptr;
    logic [KEY_W-1:0]            scan_ptr_inc;
    state_t                      state;
    state_t                      state_nxt;
    logic [AGE_W-1:0]            age  [NUM_VOICES];
    logic [KEY_W-1:0]            note [NUM_VOICES];
    logic [NUM_VOICES*AGE_W-1:0] age_packed;
    logic [VIDX_W-1:0]           sel_target;
    logic                        sel_steal;
    logic                        key_now;
    logic                        key_prev;

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + AGE_W'(1);
    endfunction

    assign key_now      = key_sync_p1[scan_ptr];
    assign key_prev     = key_state[scan_ptr];
    assign scan_ptr_inc = (scan_ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : scan_ptr + KEY_W'(1);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign age_packed[v*AGE_W +: AGE_W] = age[v];
        assign voice_note[v*KEY_W +: KEY_W] = note[v];
    end

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .VIDX_W     (VIDX_W)
    ) u_voice_select (
        .voice_active (voice_active),
        .ages         (age_packed),
        .target       (sel_target),
        .steal        (sel_steal)
    );

    // Stage p0/p1: two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            key_sync_p0 <= '0;
            key_sync_p1 <= '0;
        end else begin
            key_sync_p0 <= keys;
            key_sync_p1 <= key_sync_p0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= SCAN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = SCAN;
        case (state)
            SCAN: begin
                if (key_now && !key_prev)      state_nxt = ALLOC;
                else if (!key_now && key_prev) state_nxt = RELEASE;
                else                           state_nxt = SCAN;
            end
            ALLOC:   state_nxt = SCAN;
            RELEASE: state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    always_comb begin
        busy = (state == ALLOC) || (state == RELEASE);
    end

    // Event stage: slot table, key levels and the scan pointer.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            scan_ptr     <= '0;
            key_state    <= '0;
            voice_active <= '0;
            voice_trig   <= '0;
            steal        <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age[v]  <= '0;
                note[v] <= '0;
            end
        end else begin
            voice_trig <= '0;
            steal      <= 1'b0;
            case (state)
                SCAN: begin
                    if (state_nxt == SCAN) scan_ptr <= scan_ptr_inc;
                end
                ALLOC: begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VIDX_W'(v) == sel_target) begin
                            note[v]         <= scan_ptr;
                            voice_active[v] <= 1'b1;
                            age[v]          <= '0;
                            voice_trig[v]   <= 1'b1;
                        end else if (voice_active[v]) begin
                            age[v] <= age_sat_inc(age[v]);
                        end
                    end
                    steal               <= sel_steal;
                    key_state[scan_ptr] <= 1'b1;
                    scan_ptr            <= scan_ptr_inc;
                end
                RELEASE: begin
                    // A stolen note no longer matches any slot, so its release is a no-op.
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (voice_active[v] && note[v] == scan_ptr) voice_active[v] <= 1'b0;
                    end
                    key_state[scan_ptr] <= 1'b0;
                    scan_ptr            <= scan_ptr_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios then random single-key toggles,
// each compared against a slot-table model that orders voices by allocation time.
module tb_voice_allocator;

    localparam int NK = 13;
    localparam int NV = 4;

    logic            CLOCK_50 = 1'b0;
    logic            reset_n  = 1'b0;
    logic [NK-1:0]   keys     = '0;
    logic [NV-1:0]   voice_active;
    logic [NV*4-1:0] voice_note;
    logic [NV-1:0]   voice_trig;
    logic            steal;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    bit         m_act  [NV];
    logic [3:0] m_note [NV];
    int         m_seq  [NV];
    int         seq_ctr;
    logic [3:0] exp_trig;
    bit         exp_steal;

    voice_allocator dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .keys         (keys),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_trig   (voice_trig),
        .steal        (steal),
        .busy         (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v]  = 1'b0;
            m_note[v] = 4'd0;
            m_seq[v]  = 0;
        end
        seq_ctr   = 1;
        exp_trig  = 4'd0;
        exp_steal = 1'b0;
    endfunction

    // New note takes the first free slot, else the slot allocated longest ago.
    function void model_press(input int k);
        int tgt;
        tgt = -1;
        for (int v = 0; v < NV; v++)
            if (!m_act[v] && tgt < 0) tgt = v;
        exp_steal = 1'b0;
        if (tgt < 0) begin
            exp_steal = 1'b1;
            tgt = 0;
            for (int v = 1; v < NV; v++)
                if (m_seq[v] < m_seq[tgt]) tgt = v;
        end
        m_act[tgt]  = 1'b1;
        m_note[tgt] = 4'(k);
        m_seq[tgt]  = seq_ctr;
        seq_ctr++;
        exp_trig = 4'(1 << tgt);
    endfunction

    function void model_release(input int k);
        for (int v = 0; v < NV; v++)
            if (m_act[v] && m_note[v] == 4'(k)) m_act[v] = 1'b0;
        exp_trig  = 4'd0;
        exp_steal = 1'b0;
    endfunction

    function logic [NV-1:0] model_active();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_act[v];
        return r;
    endfunction

    function logic [NV*4-1:0] model_notes();
        logic [NV*4-1:0] r;
        for (int v = 0; v < NV; v++) r[v*4 +: 4] = m_note[v];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_active"}, 32'(voice_active), 32'd0);
        check({tag, "_note"},   32'(voice_note),   32'd0);
        check({tag, "_trig"},   32'(voice_trig),   32'd0);
        check({tag, "_steal"},  32'(steal),        32'd0);
        check({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    // Watch a fixed window that covers sync + full scan + event, then compare.
    task automatic run_window(input string tag, input int ncyc);
        logic [NV-1:0] trig_or;
        int tcyc, scyc;
        trig_or = '0;
        tcyc = 0;
        scyc = 0;
        repeat (ncyc) begin
            @(negedge CLOCK_50);
            if (voice_trig != '0) begin
                trig_or |= voice_trig;
                tcyc++;
            end
            if (steal) scyc++;
        end
        check({tag, "_trig"},       32'(trig_or),      32'(exp_trig));
        check({tag, "_trig_len"},   32'(tcyc),         (exp_trig != 0) ? 32'd1 : 32'd0);
        check({tag, "_steal_len"},  32'(scyc),         32'(exp_steal));
        check({tag, "_active"},     32'(voice_active), 32'(model_active()));
        check({tag, "_note"},       32'(voice_note),   32'(model_notes()));
        check({tag, "_busy"},       32'(busy),         32'd0);
    endtask

    task automatic press(input int k, input string tag);
        keys[k] = 1'b1;
        model_press(k);
        run_window(tag, 24);
    endtask

    task automatic release_key(input int k, input string tag);
        keys[k] = 1'b0;
        model_release(k);
        run_window(tag, 24);
    endtask

    initial begin
        bit found;
        int k;
        model_reset();

        repeat (3) @(negedge CLOCK_50);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        run_window("idle", 24);

        press(0, "press_k0");
        check("k0_active_const", 32'(voice_active), 32'h1);
        check("k0_note_const", 32'(voice_note[3:0]), 32'h0);
        release_key(0, "release_k0");

        press(2, "press_k2");
        press(5, "press_k5");
        press(7, "press_k7");
        press(9, "press_k9");
        check("full_active_const", 32'(voice_active), 32'hF);
        check("full_note_const", 32'(voice_note), 32'h9752);

        press(11, "steal_k11");
        check("steal_note_const", 32'(voice_note), 32'h975B);
        release_key(2, "release_stolen_k2");
        release_key(7, "release_k7");
        check("rel7_active_const", 32'(voice_active), 32'hB);
        press(12, "press_k12");
        check("k12_note_const", 32'(voice_note), 32'h9C5B);

        // Key held high across reset.
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        keys = 13'h0008;
        repeat (3) @(negedge CLOCK_50);
        check_idle_outputs("held_rst");
        reset_n = 1'b1;
        model_reset();
        model_press(3);
        run_window("held_k3", 16);
        check("held_k3_note_const", 32'(voice_note[3:0]), 32'h3);

        // Reset asserted between edges while an allocation is in flight.
        keys[6] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            @(negedge CLOCK_50);
            if (busy) found = 1'b1;
        end
        check("alloc_seen", 32'(found), 32'd1);
        #3 reset_n = 1'b0;
        #1 check_idle_outputs("mid_alloc_rst");
        found = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            if (voice_trig != '0 || voice_active != '0) found = 1'b1;
        end
        check("mid_alloc_quiet", 32'(found), 32'd0);
        keys = 13'h0040;
        reset_n = 1'b1;
        model_reset();
        model_press(6);
        run_window("after_abort_k6", 24);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, NK - 1));
            if (keys[k]) release_key(k, "rand_release");
            else         press(k, "rand_press");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
